// File: rtl/dds_mod_core.sv
// dds_mod_core: pipelined quarter-wave DDS with CW/FSK/BPSK modes and wrap-aligned config updates.
// The sine table is computed at elaboration, so no external ROM image is needed.
module dds_mod_core #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 6,
  parameter int OUT_W   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [PHASE_W-1:0]      ftw0,
  input  logic [PHASE_W-1:0]      ftw1,
  input  logic [PHASE_W-1:0]      poff,
  input  logic [1:0]              mode,
  input  logic                    sym_bit,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out
);
  localparam int PW = LUT_AW + 2;
  localparam longint ONE = 64'sd1 << 30;
  localparam longint PI_FIX = 64'sd3373259426;
  localparam longint AMP = (64'sd1 << (OUT_W - 1)) - 64'sd1;
  // round(AMP * sin(pi/2 * (k + 0.5) / 2^LUT_AW)) via a Q30 Taylor series
  function automatic logic [OUT_W-2:0] sine_entry(input longint k);
    longint x, term, sum;
    x = PI_FIX * (2 * k + 1) / (64'sd1 << PW);
    term = x;
    sum = x;
    for (longint i = 1; i < 8; i++) begin
      term = -((term * x / ONE) * x / ONE) / (2 * i * (2 * i + 1));
      sum += term;
    end
    return (OUT_W-1)'((sum * AMP + ONE / 2) / ONE);
  endfunction
  logic [OUT_W-2:0] rom [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam logic [OUT_W-2:0] V = sine_entry(longint'(k));
    assign rom[k] = V;
  end
  logic [PHASE_W-1:0] acc, a_ftw0, a_ftw1, a_poff, s_ftw0, s_ftw1, s_poff;
  logic [PHASE_W-1:0] ftw_sel, flip;
  logic [PHASE_W:0]   acc_sum;
  logic [1:0]         a_mode, s_mode;
  logic               pending, wrap, commit;
  logic [PW-1:0]      ph_next, ph_q;
  logic [LUT_AW-1:0]  addr_q;
  logic               neg2, neg3;
  logic [OUT_W-2:0]   rom_q;
  logic signed [OUT_W-1:0] mag;
  logic [3:0]         vld;
  assign cfg_ready = !pending;
  assign out_valid = vld[3];
  assign mag = {1'b0, rom_q};
  always_comb begin
    ftw_sel = (a_mode == 2'b01 && sym_bit) ? a_ftw1 : a_ftw0;
    acc_sum = {1'b0, acc} + {1'b0, ftw_sel};
    wrap = en && acc_sum[PHASE_W];
    // an empty step (en low or zero tuning word) is as safe a swap point as a wrap
    commit = pending && (wrap || !en || ftw_sel == '0);
    flip = {(a_mode == 2'b10) && sym_bit, {(PHASE_W-1){1'b0}}};
    ph_next = PW'((acc + a_poff + flip) >> (PHASE_W - PW));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      pending <= 1'b0;
      a_ftw0 <= '0;
      a_ftw1 <= '0;
      a_poff <= '0;
      a_mode <= 2'b00;
      s_ftw0 <= '0;
      s_ftw1 <= '0;
      s_poff <= '0;
      s_mode <= 2'b00;
    end else begin
      if (en) acc <= acc_sum[PHASE_W-1:0];
      if (cfg_valid && !pending) begin
        pending <= 1'b1;
        s_ftw0 <= ftw0;
        s_ftw1 <= ftw1;
        s_poff <= poff;
        s_mode <= mode;
      end else if (commit) begin
        pending <= 1'b0;
        a_ftw0 <= s_ftw0;
        a_ftw1 <= s_ftw1;
        a_poff <= s_poff;
        a_mode <= s_mode;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ph_q <= '0;
      addr_q <= '0;
      neg2 <= 1'b0;
      rom_q <= '0;
      neg3 <= 1'b0;
      vld <= '0;
      out <= '0;
    end else begin
      ph_q <= ph_next;
      addr_q <= ph_q[LUT_AW] ? ~ph_q[LUT_AW-1:0] : ph_q[LUT_AW-1:0];
      neg2 <= ph_q[PW-1];
      rom_q <= rom[addr_q];
      neg3 <= neg2;
      vld <= {vld[2:0], en};
      if (vld[2]) out <= neg3 ? -mag : mag;
    end
endmodule
